// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// regfile_2r1w_if: write, dual-read and clear-sweep signals of the 2R1W register file.
// Revision: 1.0
interface regfile_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr0;
  logic [DATA_W-1:0] rd_data0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic              clr_;
  logic              busy;
  logic              wr_err;

  modport master (
    output we_, wr_addr, wr_data, rd_addr0, rd_addr1, clr_,
    input  rd_data0, rd_data1, busy, wr_err
  );

  modport slave (
    input  we_, wr_addr, wr_data, rd_addr0, rd_addr1, clr_,
    output rd_data0, rd_data1, busy, wr_err
  );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// regfile_2r1w: flip-flop register file, one write and two combinational read ports,
// optional write-to-read bypass and a DEPTH-cycle hardware clear sweep. Revision: 1.0
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset_,
  regfile_2r1w_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_SWEEP  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W:0]   cnt;
  logic              busy;
  logic              wr_addr_ok;
  logic              write_ok;
  logic              wr_err;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign wr_addr_ok = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign write_ok   = !bus.we_ && !busy && wr_addr_ok;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A low clr_ seen while already sweeping is ignored; the sweep never restarts.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!bus.clr_) state_nxt = ST_SWEEP;
      ST_SWEEP: if (cnt == LAST_IDX) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == ST_SWEEP) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (busy && (cnt != LAST_IDX)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Write and sweep never coincide: a write needs busy low, the sweep needs busy high.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else if (write_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= !bus.we_ && (busy || !wr_addr_ok);
    end
  end

  assign rd_addr[0] = bus.rd_addr0;
  assign rd_addr[1] = bus.rd_addr1;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd_data[p] = '0;
      if ({1'b0, rd_addr[p]} < DEPTH_EXT) rd_data[p] = mem[rd_addr[p]];
      if ((BYPASS != 0) && write_ok && (rd_addr[p] == bus.wr_addr)) rd_data[p] = bus.wr_data;
    end
  end

  assign bus.rd_data0 = rd_data[0];
  assign bus.rd_data1 = rd_data[1];
  assign bus.busy     = busy;
  assign bus.wr_err   = wr_err;
endmodule
`default_nettype wire
